// File: rtl/fetch_line_buffer_pkg.sv
// Shared types and constants for the instruction-fetch line buffer.
// Holds the fetch FSM encoding, the data widths and the line-address helper.
package fetch_line_buffer_pkg;

    localparam int XLEN           = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = LINE_W / XLEN;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4
    } fetch_state_t;

    function automatic logic [XLEN-1:0] line_base(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/fetch_line_buffer_chk.sv
// Protocol checker for the fetch line buffer memory port.
// Read data may only arrive while the fetch unit is waiting for it or discarding it.
module fetch_line_buffer_chk (
    input logic clk,
    input logic rst_n,
    input logic mem_rvalid,
    input logic rvalid_expected
);

    a_rvalid_in_window: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid |-> rvalid_expected);

endmodule

// File: rtl/fetch_line_buffer.sv
// Instruction-fetch front end: reads one 128-bit line at a time and
// hands out its 32-bit words with their PCs; a redirect restarts fetch.
module fetch_line_buffer
    import fetch_line_buffer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic              instr_valid_o,
    output logic [XLEN-1:0]   instr_o,
    output logic [XLEN-1:0]   instr_pc_o,
    input  logic              instr_ready_i
);

    fetch_state_t      state_r, state_s;
    logic [XLEN-1:0]   pc_r, pc_s, pc_adv_s;
    logic [LINE_W-1:0] line_r, line_s;
    logic [1:0]        idx_r, idx_s;

    logic              transfer_s;
    logic [XLEN-1:0]   redirect_pc_s;
    logic              mem_req_s;
    logic [XLEN-1:0]   mem_addr_s;
    logic              instr_valid_s;
    logic [XLEN-1:0]   instr_s;
    logic [XLEN-1:0]   instr_pc_s;
    logic [XLEN-1:0]   word_s;

    // instr_valid_o is registered from state==DRAIN, so it doubles as the DRAIN flag
    assign transfer_s    = instr_valid_o & instr_ready_i;
    assign redirect_pc_s = {redirect_pc_i[XLEN-1:2], 2'b00};

    // State, PC, line and word-index registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            line_r  <= {LINE_W{1'b0}};
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            line_r  <= line_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state logic; a redirect overrides the PC in every state
    always_comb begin
        state_s  = state_r;
        pc_adv_s = pc_r;
        line_s   = line_r;
        idx_s    = idx_r;
        case (state_r)
            IDLE: state_s = REQ;
            REQ: begin
                if (mem_gnt_i) begin
                    state_s = redirect_i ? FLUSH : WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid_i && redirect_i) begin
                    state_s = REQ;
                end else if (mem_rvalid_i) begin
                    state_s = DRAIN;
                    line_s  = mem_rdata_i;
                    idx_s   = pc_r[3:2];
                end else if (redirect_i) begin
                    state_s = FLUSH;
                end else begin
                    state_s = WAIT;
                end
            end
            DRAIN: begin
                if (redirect_i) begin
                    state_s = REQ;
                end else if (transfer_s && (idx_r == 2'd3)) begin
                    state_s  = REQ;
                    pc_adv_s = line_base(pc_r) + 32'd16;
                end else if (transfer_s) begin
                    idx_s = idx_r + 2'd1;
                end else begin
                    state_s = DRAIN;
                end
            end
            FLUSH: begin
                if (mem_rvalid_i) begin
                    state_s = REQ;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: state_s = IDLE;
        endcase
        pc_s = redirect_i ? redirect_pc_s : pc_adv_s;
    end

    // Next output values, derived from the next state so the outputs stay registered
    always_comb begin
        case (idx_s)
            2'd0:    word_s = line_s[0*XLEN +: XLEN];
            2'd1:    word_s = line_s[1*XLEN +: XLEN];
            2'd2:    word_s = line_s[2*XLEN +: XLEN];
            2'd3:    word_s = line_s[3*XLEN +: XLEN];
            default: word_s = line_s[0*XLEN +: XLEN];
        endcase
        mem_req_s     = (state_s == REQ);
        mem_addr_s    = mem_req_s ? line_base(pc_s) : mem_addr_o;
        instr_valid_s = (state_s == DRAIN);
        instr_s       = instr_valid_s ? word_s : instr_o;
        instr_pc_s    = instr_valid_s ? {pc_s[XLEN-1:4], idx_s, 2'b00} : instr_pc_o;
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_req_o     <= 1'b0;
            mem_addr_o    <= {XLEN{1'b0}};
            instr_valid_o <= 1'b0;
            instr_o       <= {XLEN{1'b0}};
            instr_pc_o    <= {XLEN{1'b0}};
        end else begin
            mem_req_o     <= mem_req_s;
            mem_addr_o    <= mem_addr_s;
            instr_valid_o <= instr_valid_s;
            instr_o       <= instr_s;
            instr_pc_o    <= instr_pc_s;
        end
    end

    fetch_line_buffer_chk u_chk (
        .clk             (CLK),
        .rst_n           (RST_N),
        .mem_rvalid      (mem_rvalid_i),
        .rvalid_expected ((state_r == WAIT) || (state_r == FLUSH))
    );

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Randomized bench for fetch_line_buffer: a memory model drives the RAM port and a
// negedge monitor checks the instruction stream against a PC-sequence scoreboard.
module tb_fetch_line_buffer;

    localparam int NCYC = 20000;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         redirect_i = 1'b0;
    logic [31:0]  redirect_pc_i = 32'd0;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i = 1'b0;
    logic         mem_rvalid_i = 1'b0;
    logic [127:0] mem_rdata_i = 128'd0;
    logic         instr_valid_o;
    logic [31:0]  instr_o;
    logic [31:0]  instr_pc_o;
    logic         instr_ready_i = 1'b0;

    int checks = 0;
    int fails  = 0;
    bit done   = 1'b0;

    fetch_line_buffer #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 CLK = ~CLK;

    // Memory contents: line 0 holds the reference program, everything else is a hash of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[31:2])
            30'd0:   return 32'h305a5073;
            30'd1:   return 32'h00000073;
            30'd2:   return 32'h00100073;
            30'd3:   return 32'h000fffe7;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] b);
        return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus: reset, memory responder, decode backpressure and redirects
    initial begin
        int          cnt;
        bit          pending;
        bit          req_seen;
        logic [31:0] addr_seen;
        logic [31:0] paddr;
        logic [31:0] tgt;
        cnt = 0; pending = 1'b0; req_seen = 1'b0; addr_seen = 32'd0; paddr = 32'd0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge CLK);
            #1;
            if (pending && (cyc > 50) && ($urandom % 100 == 0)) begin
                RST_N = 1'b0; pending = 1'b0; req_seen = 1'b0;
                mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; redirect_i = 1'b0;
                repeat (2) @(posedge CLK);
                #1 RST_N = 1'b1;
                continue;
            end
            if (req_seen && mem_gnt_i) begin
                pending = 1'b1; paddr = addr_seen; cnt = $urandom_range(1, 3);
            end
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = line_data(paddr); pending = 1'b0;
                end
            end
            mem_gnt_i     = (cyc < 20) ? 1'b1 : (($urandom % 2) == 1);
            instr_ready_i = (cyc < 20) ? 1'b1 : (($urandom % 4) != 0);
            redirect_i    = (cyc >= 20) && (($urandom % 40) == 0);
            case ($urandom % 6)
                0:       tgt = 32'h0000_0028;
                1:       tgt = 32'h0000_0040;
                2:       tgt = 32'hFFFF_FFFC;
                3:       tgt = 32'hFFFF_FFF0;
                4:       tgt = $urandom % 32'h100;
                default: tgt = $urandom;
            endcase
            redirect_pc_i = tgt | ($urandom % 4);
            req_seen  = mem_req_o;
            addr_seen = mem_addr_o;
        end
        done = 1'b1;
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Monitor and scoreboard: expected (pc, instr) pairs for the rest of the current line
    initial begin
        logic [63:0] q[$];
        logic [63:0] e;
        logic [31:0] model_pc;
        logic [31:0] a;
        logic [31:0] hold_instr, hold_pc;
        int          since_rst, idle_cnt, ntx;
        bit          outstanding, prev_redir, prev_hold, final_done;
        model_pc = 32'd0; since_rst = 0; idle_cnt = 0; ntx = 0;
        outstanding = 1'b0; prev_redir = 1'b0; prev_hold = 1'b0; final_done = 1'b0;
        hold_instr = 32'd0; hold_pc = 32'd0;
        forever begin
            @(negedge CLK);
            if (done && !final_done) begin
                final_done = 1'b1;
                chk("enough_transfers", 32'(ntx > 500), 32'd1);
            end
            if (!RST_N) begin
                chk("rst_mem_req", 32'(mem_req_o), 32'd0);
                chk("rst_mem_addr", mem_addr_o, 32'd0);
                chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
                chk("rst_instr", instr_o, 32'd0);
                chk("rst_instr_pc", instr_pc_o, 32'd0);
                q.delete(); model_pc = 32'd0; since_rst = 0; idle_cnt = 0;
                outstanding = 1'b0; prev_redir = 1'b0; prev_hold = 1'b0;
                continue;
            end
            since_rst++;
            if (since_rst == 1) chk("idle_after_reset", 32'(mem_req_o), 32'd0);
            if (since_rst == 2) chk("req_cycle1_after_reset", 32'(mem_req_o), 32'd1);
            if (q.size() == 0) begin
                a = model_pc;
                q.push_back({a, mem_word(a)});
                while (a[3:2] != 2'd3) begin
                    a = a + 32'd4;
                    q.push_back({a, mem_word(a)});
                end
                model_pc = {model_pc[31:4], 4'b0000} + 32'd16;
            end
            if (prev_redir) chk("valid_after_redirect", 32'(instr_valid_o), 32'd0);
            if (prev_hold) begin
                chk("hold_valid", 32'(instr_valid_o), 32'd1);
                chk("hold_instr", instr_o, hold_instr);
                chk("hold_pc", instr_pc_o, hold_pc);
            end
            if (mem_req_o) begin
                e = q[0];
                chk("req_addr", mem_addr_o, {e[63:36], 4'b0000});
                if (mem_gnt_i) chk("single_outstanding", 32'(outstanding), 32'd0);
            end
            if (mem_rvalid_i) outstanding = 1'b0;
            if (mem_req_o && mem_gnt_i) outstanding = 1'b1;
            if (instr_valid_o && instr_ready_i) begin
                e = q.pop_front();
                chk("instr_pc", instr_pc_o, e[63:32]);
                chk("instr", instr_o, e[31:0]);
                ntx++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (idle_cnt > 300) begin
                checks++; fails++;
                $display("FAIL watchdog: no instruction transfer for %0d cycles", idle_cnt);
                idle_cnt = 0;
            end
            if (redirect_i) begin
                q.delete();
                model_pc = {redirect_pc_i[31:2], 2'b00};
            end
            prev_redir = redirect_i;
            prev_hold  = instr_valid_o && !instr_ready_i && !redirect_i;
            hold_instr = instr_o;
            hold_pc    = instr_pc_o;
        end
    end

endmodule
